// File: rtl/pixel_tone_adjust_pkg.sv
// Shared definitions for the pixel tone adjuster: mode encoding and default parameters.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pixel_tone_adjust_pkg;

   // Output mode selector values for the mode port.
   typedef enum logic [1:0] {
      MODE_RGB   = 2'b00,   // luminance/saturation adjusted colour
      MODE_GREY  = 2'b01,   // weighted grey of the adjusted colour
      MODE_SKIN  = 2'b10,   // binary mask from the skin classifier flag
      MODE_GREEN = 2'b11    // binary mask from the green classifier flag
   } mode_e;

   localparam int DEF_PIX_W      = 10;
   localparam int DEF_STEP_W     = 4;
   localparam int DEF_LUM_SCALE  = 50;
   localparam int DEF_SAT_SCALE  = 20;
   localparam int DEF_REPEAT_CYC = 1000000;

endpackage

// File: rtl/tone_step_counter.sv
// Saturating up/down setting driven by two active-low push-buttons with hold-to-repeat.
// Latency: setting changes on the clk edge after a press/repeat event.
// Backpressure: none; events are never dropped or queued.
//
// Ports: clk, rst (async active-low), i_add_n / i_sub_n (buttons, pressed = 0),
//        o_value (current setting, STEP_W bits).
module tone_step_counter
   import pixel_tone_adjust_pkg::*;
#(
   parameter int STEP_W     = DEF_STEP_W,
   parameter int REPEAT_CYC = DEF_REPEAT_CYC
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_add_n,
   input  logic              i_sub_n,
   output logic [STEP_W-1:0] o_value
);

   localparam int               CNT_W    = $clog2(REPEAT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_REP  = CNT_W'(REPEAT_CYC);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [STEP_W-1:0] VAL_MAX = '1;

   // Index 0 is the add button, index 1 the sub button.
   logic [1:0]       w_btn_n;
   logic [1:0]       w_press;
   logic [1:0]       w_rep;
   logic [1:0]       w_ev;
   logic [1:0]       r_prev;
   logic [1:0]       r_armed;
   logic [CNT_W-1:0] r_cnt [2];
   logic [STEP_W-1:0] r_value;

   assign w_btn_n = {i_sub_n, i_add_n};

   // r_armed stays low until the button has been seen released after reset,
   // so a button held through reset release cannot fake a press.
   // r_cnt is non-zero only while a validly pressed button is still held;
   // it counts cycles since the last event on that button.
   always_comb begin
      w_press = '0;
      w_rep   = '0;
      for (int k = 0; k < 2; k++) begin
         w_press[k] = r_armed[k] & r_prev[k] & ~w_btn_n[k];
         w_rep[k]   = ~w_btn_n[k] & (r_cnt[k] == CNT_REP);
      end
      w_ev = w_press | w_rep;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_prev  <= 2'b11;
         r_armed <= 2'b00;
         for (int k = 0; k < 2; k++) begin
            r_cnt[k] <= '0;
         end
      end else begin
         r_prev  <= w_btn_n;
         r_armed <= r_armed | w_btn_n;
         for (int k = 0; k < 2; k++) begin
            if (w_btn_n[k]) begin
               r_cnt[k] <= '0;
            end else if (w_ev[k]) begin
               r_cnt[k] <= CNT_ONE;
            end else if (r_cnt[k] != '0) begin
               r_cnt[k] <= r_cnt[k] + CNT_ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_value <= '0;
      end else if (w_ev[0] && w_ev[1]) begin
         // Opposing events in the same cycle act as a clear.
         r_value <= '0;
      end else if (w_ev[0]) begin
         if (r_value != VAL_MAX) r_value <= r_value + STEP_W'(1);
      end else if (w_ev[1]) begin
         if (r_value != '0) r_value <= r_value - STEP_W'(1);
      end
   end

   assign o_value = r_value;

endmodule

// File: rtl/pixel_tone_adjust.sv
// Luminance/saturation pixel adjuster with grey and classifier-mask output modes.
// Latency: exactly 2 clk cycles, one pixel per cycle.
// Backpressure: none; in_valid is simply delayed to out_valid.
//
// Ports: clk, rst (async active-low); add_lum/sub_lum/add_sat/sub_sat buttons (pressed = 0);
//        mode; in_valid, in_red/green/blue, in_is_skin/in_is_green (input pixel);
//        out_valid, out_red/green/blue, out_is_skin/out_is_green (output pixel);
//        luminance, saturation (current settings).
module pixel_tone_adjust
   import pixel_tone_adjust_pkg::*;
#(
   parameter int PIX_W      = DEF_PIX_W,
   parameter int STEP_W     = DEF_STEP_W,
   parameter int LUM_SCALE  = DEF_LUM_SCALE,
   parameter int SAT_SCALE  = DEF_SAT_SCALE,
   parameter int REPEAT_CYC = DEF_REPEAT_CYC
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              add_lum,
   input  logic              sub_lum,
   input  logic              add_sat,
   input  logic              sub_sat,
   input  logic [1:0]        mode,
   input  logic              in_valid,
   input  logic [PIX_W-1:0]  in_red,
   input  logic [PIX_W-1:0]  in_green,
   input  logic [PIX_W-1:0]  in_blue,
   input  logic              in_is_skin,
   input  logic              in_is_green,
   output logic              out_valid,
   output logic [PIX_W-1:0]  out_red,
   output logic [PIX_W-1:0]  out_green,
   output logic [PIX_W-1:0]  out_blue,
   output logic              out_is_skin,
   output logic              out_is_green,
   output logic [STEP_W-1:0] luminance,
   output logic [STEP_W-1:0] saturation
);

   // Wide enough that R+D+E cannot overflow and G+D-E keeps its sign.
   localparam int                    CW    = PIX_W + STEP_W + 8;
   localparam logic signed [CW-1:0]  C_MAX = CW'(2**PIX_W - 1);

   logic [STEP_W-1:0] w_lum;
   logic [STEP_W-1:0] w_sat;

   tone_step_counter #(.STEP_W(STEP_W), .REPEAT_CYC(REPEAT_CYC)) u_lum_step (
      .clk     (clk),
      .rst     (rst),
      .i_add_n (add_lum),
      .i_sub_n (sub_lum),
      .o_value (w_lum)
   );

   tone_step_counter #(.STEP_W(STEP_W), .REPEAT_CYC(REPEAT_CYC)) u_sat_step (
      .clk     (clk),
      .rst     (rst),
      .i_add_n (add_sat),
      .i_sub_n (sub_sat),
      .o_value (w_sat)
   );

   // Stage 1: pixel plus the mode and settings in force when it arrived.
   logic              r1_vld;
   logic [PIX_W-1:0]  r1_red;
   logic [PIX_W-1:0]  r1_grn;
   logic [PIX_W-1:0]  r1_blu;
   logic              r1_is_skin;
   logic              r1_is_green;
   mode_e             r1_mode;
   logic [STEP_W-1:0] r1_lum;
   logic [STEP_W-1:0] r1_sat;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r1_vld      <= 1'b0;
         r1_red      <= '0;
         r1_grn      <= '0;
         r1_blu      <= '0;
         r1_is_skin  <= 1'b0;
         r1_is_green <= 1'b0;
         r1_mode     <= MODE_RGB;
         r1_lum      <= '0;
         r1_sat      <= '0;
      end else begin
         r1_vld      <= in_valid;
         r1_red      <= in_red;
         r1_grn      <= in_green;
         r1_blu      <= in_blue;
         r1_is_skin  <= in_is_skin;
         r1_is_green <= in_is_green;
         r1_mode     <= mode_e'(mode);
         r1_lum      <= w_lum;
         r1_sat      <= w_sat;
      end
   end

   function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [CW-1:0] v);
      if (v[CW-1])         return '0;
      else if (v > C_MAX)  return '1;
      else                 return v[PIX_W-1:0];
   endfunction

   logic signed [CW-1:0] w_d;
   logic signed [CW-1:0] w_e;
   logic signed [CW-1:0] w_r_sum;
   logic signed [CW-1:0] w_g_sum;
   logic signed [CW-1:0] w_b_sum;
   logic [PIX_W-1:0]     w_ra;
   logic [PIX_W-1:0]     w_ga;
   logic [PIX_W-1:0]     w_ba;
   logic [PIX_W+1:0]     w_grey_sum;
   logic [PIX_W-1:0]     w_grey;

   assign w_d     = CW'(r1_lum) * CW'(LUM_SCALE);
   assign w_e     = CW'(r1_sat) * CW'(SAT_SCALE);
   // Saturation pulls green down and pushes blue up around the luminance offset.
   assign w_r_sum = $signed(CW'(r1_red)) + w_d;
   assign w_g_sum = $signed(CW'(r1_grn)) + w_d - w_e;
   assign w_b_sum = $signed(CW'(r1_blu)) + w_d + w_e;
   assign w_ra    = clamp_pix(w_r_sum);
   assign w_ga    = clamp_pix(w_g_sum);
   assign w_ba    = clamp_pix(w_b_sum);

   // (R + 2G + B) / 4 never exceeds MAX, so the shifted sum fits PIX_W bits.
   assign w_grey_sum = {2'b00, w_ra} + {1'b0, w_ga, 1'b0} + {2'b00, w_ba};
   assign w_grey     = PIX_W'(w_grey_sum >> 2);

   logic [PIX_W-1:0] w_o_red;
   logic [PIX_W-1:0] w_o_grn;
   logic [PIX_W-1:0] w_o_blu;

   always_comb begin
      w_o_red = w_ra;
      w_o_grn = w_ga;
      w_o_blu = w_ba;
      case (r1_mode)
         MODE_GREY: begin
            w_o_red = w_grey;
            w_o_grn = w_grey;
            w_o_blu = w_grey;
         end
         MODE_SKIN: begin
            w_o_red = {PIX_W{r1_is_skin}};
            w_o_grn = {PIX_W{r1_is_skin}};
            w_o_blu = {PIX_W{r1_is_skin}};
         end
         MODE_GREEN: begin
            w_o_red = {PIX_W{r1_is_green}};
            w_o_grn = {PIX_W{r1_is_green}};
            w_o_blu = {PIX_W{r1_is_green}};
         end
         default: ;
      endcase
   end

   // Stage 2: registered outputs.
   logic             r2_vld;
   logic [PIX_W-1:0] r2_red;
   logic [PIX_W-1:0] r2_grn;
   logic [PIX_W-1:0] r2_blu;
   logic             r2_is_skin;
   logic             r2_is_green;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r2_vld      <= 1'b0;
         r2_red      <= '0;
         r2_grn      <= '0;
         r2_blu      <= '0;
         r2_is_skin  <= 1'b0;
         r2_is_green <= 1'b0;
      end else begin
         r2_vld      <= r1_vld;
         r2_red      <= w_o_red;
         r2_grn      <= w_o_grn;
         r2_blu      <= w_o_blu;
         r2_is_skin  <= r1_is_skin;
         r2_is_green <= r1_is_green;
      end
   end

   assign out_valid    = r2_vld;
   assign out_red      = r2_red;
   assign out_green    = r2_grn;
   assign out_blue     = r2_blu;
   assign out_is_skin  = r2_is_skin;
   assign out_is_green = r2_is_green;
   assign luminance    = w_lum;
   assign saturation   = w_sat;

endmodule

// File: doc/pixel_tone_adjust.md
PIXEL_TONE_ADJUST -- requirements
Module: pixel_tone_adjust

Interface
REQ-001 SHALL have parameter PIX_W, default 10, colour channel width.
REQ-002 SHALL have parameter STEP_W, default 4, luminance/saturation setting width.
REQ-003 SHALL have parameter LUM_SCALE, default 50, per-step luminance increment.
REQ-004 SHALL have parameter SAT_SCALE, default 20, per-step saturation increment.
REQ-005 SHALL have parameter REPEAT_CYC, default 1000000, hold-to-repeat period in clk cycles (>=2).
REQ-006 clk  in  1  clock; reset rst, asynchronous, active-low; clock clk.
REQ-007 rst  in  1  asynchronous active-low reset.
REQ-008 add_lum, sub_lum, add_sat, sub_sat  in  1 each  active-low push-buttons (pressed = 0).
REQ-009 mode  in  2  00 adjusted RGB, 01 grey, 10 skin mask, 11 green mask.
REQ-010 in_valid  in  1  input pixel qualifier.
REQ-011 in_red, in_green, in_blue  in  PIX_W each  input pixel.
REQ-012 in_is_skin, in_is_green  in  1 each  per-pixel classifier flags.
REQ-013 out_valid  out  1  output pixel qualifier.
REQ-014 out_red, out_green, out_blue  out  PIX_W each  output pixel.
REQ-015 out_is_skin, out_is_green  out  1 each  flags aligned to the output pixel.
REQ-016 luminance, saturation  out  STEP_W each  current settings.

Function
REQ-017 Each button SHALL produce a step event on its 1->0 transition (sampled on clk).
REQ-018 While a button stays 0, a repeat event SHALL fire every REPEAT_CYC cycles after the press event; release SHALL clear that button's repeat counter.
REQ-019 An add event alone SHALL increment the setting, saturating at 2^STEP_W-1; a sub event alone SHALL decrement, saturating at 0.
REQ-020 Add and sub events for the same setting in the same cycle SHALL clear that setting to 0.
REQ-021 Settings SHALL update on the clock edge following the event cycle.
REQ-022 Let D=luminance*LUM_SCALE, E=saturation*SAT_SCALE, MAX=2^PIX_W-1; computed in at least PIX_W+STEP_W+8 bits with no overflow.
REQ-023 Adjusted R'=min(R+D,MAX); G'=clamp(G+D-E,0,MAX); B'=min(B+D+E,MAX).
REQ-024 Mode 00 SHALL output R',G',B'; mode 01 SHALL output (R'+2G'+B')>>2 on all channels.
REQ-025 Mode 10 SHALL output MAX on all channels when is_skin=1, else 0; mode 11 the same using is_green.
REQ-026 Pipeline SHALL be two registered stages: stage 1 captures pixel, flags, valid, mode and settings; stage 2 registers computed outputs; latency exactly 2 cycles, throughput one pixel per cycle, no backpressure.
REQ-027 Mode and settings SHALL be sampled per pixel at stage 1; a mid-stream change SHALL affect only pixels entering on or after the change.
REQ-028 out_valid SHALL follow in_valid delayed 2 cycles; pixel data SHALL be registered regardless of in_valid.
REQ-029 out_is_skin/out_is_green SHALL be the input flags delayed 2 cycles in every mode.

Reset
REQ-030 On rst=0 all outputs, settings, pipeline registers and repeat counters SHALL be 0; previous-button registers SHALL reset to 1 (released).
REQ-031 Reset mid-stream SHALL discard in-flight pixels; out_valid SHALL be 0 for the first 2 cycles after release.
REQ-032 A button held during reset release SHALL NOT produce a press event until released and pressed again.

Structure
REQ-033 Shared package SHALL hold the mode encoding constants and the default parameter values.
REQ-034 One sub-module, tone_step_counter (edge detect, hold-repeat, saturating up/down counter), SHALL be instantiated twice (luminance, saturation).

Verification (PIX_W=10, STEP_W=4, LUM_SCALE=50, SAT_SCALE=20, REPEAT_CYC=8)
REQ-035 Reset, then idle 5 cycles -> all outputs 0, luminance=saturation=0, out_valid=0.
REQ-036 One add_lum press, then pixel (1000,100,10) mode 00 -> luminance=1; output (1023,150,60) exactly 2 cycles after the pixel.
REQ-037 saturation=3, luminance=0, pixel (500,40,10) mode 00 -> output (500,0,70); mode 01 with (400,400,400), settings 0 -> (400,400,400).
REQ-038 20 add_sat presses -> saturation 15; simultaneous add_sat/sub_sat press -> saturation 0; sub at 0 stays 0.
REQ-039 add_lum held low 20 cycles from luminance 0 -> events at press, +8, +16; luminance 3; release then no further change.
REQ-040 Mode 10, is_skin toggling 1,0,1 -> outputs 1023,0,1023 with out_is_skin matching, 2-cycle aligned; rst pulse mid-stream -> outputs 0 immediately.
